shift_result_queue: RTL and testbench
=====================================

Name: shift_result_queue

Overview:
- Downstream of the execute-stage shifter. Captures each 64-bit shifter result together with its destination register index.
- Buffers results in a small circular FIFO and presents them to the register-file writeback port over a valid/ready handshake.
- Decouples the combinational shifter from writeback stalls.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of two and at least 2.
- DATA_W, 64, result width; matches the shifter output.
- REG_W, 5, destination register index width (32 architectural registers).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  the shifter result and in_rd are valid this cycle.
- in_ready  output  1  the queue accepts an entry this cycle.
- in_result  input  DATA_W  signed shifter result.
- in_rd  input  REG_W  destination register index.
- wb_valid  output  1  the head entry is valid.
- wb_ready  input  1  writeback consumes the head this cycle.
- wb_data  output  DATA_W  head entry result.
- wb_rd  output  REG_W  head entry destination.
- count  output  log2(DEPTH)+1  number of occupied entries.
- full  output  1  count equals DEPTH.
- empty  output  1  count equals 0.

Behaviour:
- Reset (asynchronous, immediate): write pointer = 0, read pointer = 0, count = 0. Outputs take wb_valid=0, empty=1, full=0, wb_data=0, wb_rd=0. Storage array contents are not reset.
- Push: occurs when in_valid and in_ready are both high at a clock edge. The entry is written at the write pointer, and the write pointer increments modulo DEPTH (natural wrap).
- Pop: occurs when wb_valid and wb_ready are both high at a clock edge. The read pointer increments modulo DEPTH.
- in_ready = !full. There is no pass-through when full: a simultaneous pop on a full queue does not admit a push in the same cycle.
- wb_valid = !empty. wb_data and wb_rd are driven combinationally from the entry at the read pointer and forced to 0 when empty.
- Latency: a push into an empty queue appears on wb_* in the next cycle. There is no same-cycle bypass.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together (non-empty, non-full): unchanged, both pointers advance.
- Push while empty together with wb_ready high: only the push takes effect, because wb_valid was 0.
- Pushes with in_valid high while full are ignored. The upstream stage must hold its data stable until in_ready is high.
- Popping while empty is impossible by construction; wb_ready is ignored when empty.
- Data is stored bit-exact. There is no sign extension or truncation because DATA_W matches the shifter output.
- Ordering is strict FIFO. No entry is dropped or reordered.
- Reset asserted mid-operation discards all entries immediately. The first push after reset is deasserted lands in entry 0.

Optional Feature:
- Macro: SHIFT_RESULT_QUEUE_HAZARD_EN.
- With the macro defined, two extra ports are added:
  - query_rd input REG_W.
  - query_hit output 1, which is high combinationally when any occupied entry holds wb_rd equal to query_rd.
- Occupancy is tracked by a per-entry valid bit. Each bit is set on push, cleared on pop, and cleared on reset.
- query_hit does not observe a push happening in the same cycle.
- This port lets the decode stage stall on a read-after-write hazard against results still queued.
- Without the macro: the ports, the valid-bit vector and the comparators are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - DATA_W and REG_W constants, shared with the shifter and the register file.
  - A result-entry struct typedef {data, rd}.
  - The clog2-based pointer-width constant.
- One natural sub-module: shift_result_queue_ptr, a modulo-DEPTH pointer register with increment enable and asynchronous reset, instantiated twice.
- The storage array and count logic stay in the top module.

Test Plan:
- Reset then idle → wb_valid=0, empty=1, full=0, count=0, wb_data=0.
- Push 0x0000_0000_0000_00F0 with rd=3 into an empty queue → next cycle wb_valid=1, wb_data=0xF0, wb_rd=3, count=1. Pulse wb_ready → empty=1.
- Push four entries (0x1, 0x2, 0x4, 0x8; rd 1–4) with wb_ready=0 → full=1, in_ready=0. A fifth push of 0x10 is ignored. Draining yields 0x1, 0x2, 0x4, 0x8 in order.
- Wrap: push/pop continuously for 10 cycles with values 0x8000_0000_0000_0000 >> n → outputs appear in order, count stays 1, and the pointers wrap past DEPTH correctly.
- Full queue with simultaneous in_valid=1 and wb_ready=1 → a pop occurs, the push is rejected, count=3 the next cycle.
- Assert reset while count=3 → count=0 and wb_valid=0 immediately, without waiting for a clock edge. With SHIFT_RESULT_QUEUE_HAZARD_EN defined: push rd=7, query_rd=7 → query_hit=1; after the pop → query_hit=0.

Source files
------------

// File: rtl/shift_result_queue_pkg.sv
// ============================================================================
// shift_result_queue_pkg
// Shared widths, the queued result entry, and pointer-width helpers for the
// shifter result queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

package shift_result_queue_pkg;

  localparam int RESULT_W    = 64;
  localparam int RD_W        = 5;
  localparam int QUEUE_DEPTH = 4;

  typedef struct packed {
    logic [RESULT_W-1:0] data;
    logic [RD_W-1:0]     rd;
  } result_entry_t;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PTR_W = ptr_width(QUEUE_DEPTH);

  function automatic result_entry_t make_entry(input logic [RESULT_W-1:0] data,
                                               input logic [RD_W-1:0]     rd);
    result_entry_t e;
    e.data = data;
    e.rd   = rd;
    return e;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_result_queue_ptr.sv
// ============================================================================
// shift_result_queue_ptr
// Modulo-DEPTH pointer register; DEPTH is a power of two so wrap is natural.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_result_queue_ptr #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_result_queue.sv
// ============================================================================
// shift_result_queue
// Circular FIFO of shifter results feeding the writeback port (valid/ready).
// Optional hazard query port enabled by SHIFT_RESULT_QUEUE_HAZARD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_result_queue
  import shift_result_queue_pkg::*;
#(
  parameter int DEPTH  = QUEUE_DEPTH,
  parameter int DATA_W = RESULT_W,
  parameter int REG_W  = RD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_result,
  input  logic [REG_W-1:0]         in_rd,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [DATA_W-1:0]        wb_data,
  output logic [REG_W-1:0]         wb_rd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef SHIFT_RESULT_QUEUE_HAZARD_EN
  ,
  input  logic [REG_W-1:0]         query_rd,
  output logic                     query_hit
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push;
  logic           pop;
  result_entry_t  mem [DEPTH];
  result_entry_t  head;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign wb_valid = !empty;

  // No pass-through on full and no pop on empty: handshakes gate on flags.
  assign push = in_valid && in_ready;
  assign pop  = wb_valid && wb_ready;

  shift_result_queue_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (AW)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  shift_result_queue_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (AW)
  ) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= make_entry(in_result, in_rd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign wb_data = empty ? '0 : head.data;
  assign wb_rd   = empty ? '0 : head.rd;

`ifdef SHIFT_RESULT_QUEUE_HAZARD_EN
  logic [DEPTH-1:0] occupied;
  logic [DEPTH-1:0] match;

  // Set and clear never collide: push and pop share an index only when the
  // queue is empty or full, and one of them is blocked in either case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied <= '0;
    end else begin
      if (push) occupied[wr_ptr] <= 1'b1;
      if (pop)  occupied[rd_ptr] <= 1'b0;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = occupied[i] && (mem[i].rd == query_rd);
  end

  assign query_hit = |match;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shift_result_queue.sv
// ============================================================================
// tb_shift_result_queue
// Directed self-checking bench for shift_result_queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_result_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_result = '0;
  logic [4:0]  in_rd = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic [2:0]  count;
  logic        full;
  logic        empty;
`ifdef SHIFT_RESULT_QUEUE_HAZARD_EN
  logic [4:0]  query_rd = '0;
  logic        query_hit;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_result_queue dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_rd     (in_rd),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_data   (wb_data),
    .wb_rd     (wb_rd),
    .count     (count),
    .full      (full),
    .empty     (empty)
`ifdef SHIFT_RESULT_QUEUE_HAZARD_EN
    ,
    .query_rd  (query_rd),
    .query_hit (query_hit)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] d, input logic [4:0] r);
    in_valid  = 1'b1;
    in_result = d;
    in_rd     = r;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic pop_one();
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] top_bit;
    top_bit = 64'h8000_0000_0000_0000;

    #12;
    reset = 1'b0;
    step();
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_empty",    64'(empty),    64'd1);
    check("rst_full",     64'(full),     64'd0);
    check("rst_count",    64'(count),    64'd0);
    check("rst_wb_data",  wb_data,       64'd0);

    // Single push, one-cycle latency.
    push_one(64'h0000_0000_0000_00F0, 5'd3);
    check("p1_wb_valid", 64'(wb_valid), 64'd1);
    check("p1_wb_data",  wb_data,       64'hF0);
    check("p1_wb_rd",    64'(wb_rd),    64'd3);
    check("p1_count",    64'(count),    64'd1);
    pop_one();
    check("p1_empty",    64'(empty),    64'd1);

    // Push while empty with wb_ready high: only the push lands.
    in_valid = 1'b1; in_result = 64'hABCD; in_rd = 5'd6; wb_ready = 1'b1;
    step();
    in_valid = 1'b0; wb_ready = 1'b0;
    check("pe_count",   64'(count), 64'd1);
    check("pe_wb_data", wb_data,    64'hABCD);
    pop_one();

    // Fill to full, then an ignored fifth push.
    for (int i = 0; i < 4; i++) push_one(64'd1 << i, 5'(i + 1));
    check("fill_full",     64'(full),     64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);
    check("fill_count",    64'(count),    64'd4);
    push_one(64'h10, 5'd5);
    check("ovf_count",     64'(count),    64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_data", i), wb_data,       64'd1 << i);
      check($sformatf("drain%0d_rd", i),   64'(wb_rd),    64'(i + 1));
      pop_one();
    end
    check("drain_empty", 64'(empty), 64'd1);

    // Streaming push/pop across the pointer wrap.
    push_one(top_bit, 5'd0);
    for (int n = 1; n <= 10; n++) begin
      in_valid  = 1'b1;
      in_result = top_bit >> n;
      in_rd     = 5'(n);
      wb_ready  = 1'b1;
      check($sformatf("wrap%0d_data", n),  wb_data,    top_bit >> (n - 1));
      check($sformatf("wrap%0d_count", n), 64'(count), 64'd1);
      step();
    end
    in_valid = 1'b0; wb_ready = 1'b0;
    check("wrap_last_data", wb_data, top_bit >> 10);
    check("wrap_last_rd",   64'(wb_rd), 64'd10);
    pop_one();
    check("wrap_empty", 64'(empty), 64'd1);

    // Full with simultaneous push and pop: pop only.
    push_one(64'h11, 5'd11);
    push_one(64'h22, 5'd12);
    push_one(64'h33, 5'd13);
    push_one(64'h44, 5'd14);
    in_valid = 1'b1; in_result = 64'h55; in_rd = 5'd15; wb_ready = 1'b1;
    step();
    in_valid = 1'b0; wb_ready = 1'b0;
    check("fpp_count", 64'(count), 64'd3);
    check("fpp_head",  wb_data,    64'h22);

    // Asynchronous reset mid-operation.
    reset = 1'b1;
    #1;
    check("arst_count",    64'(count),    64'd0);
    check("arst_wb_valid", 64'(wb_valid), 64'd0);
    check("arst_wb_data",  wb_data,       64'd0);
    step();
    reset = 1'b0;
    step();
    push_one(64'h77, 5'd9);
    check("post_rst_data",  wb_data,    64'h77);
    check("post_rst_count", 64'(count), 64'd1);
    pop_one();

`ifdef SHIFT_RESULT_QUEUE_HAZARD_EN
    query_rd = 5'd7;
    in_valid = 1'b1; in_result = 64'h99; in_rd = 5'd7;
    #1;
    check("haz_same_cycle", 64'(query_hit), 64'd0);
    step();
    in_valid = 1'b0;
    check("haz_hit",  64'(query_hit), 64'd1);
    query_rd = 5'd8;
    #1;
    check("haz_other", 64'(query_hit), 64'd0);
    query_rd = 5'd7;
    pop_one();
    check("haz_after_pop", 64'(query_hit), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
